reg_writeback: RTL and testbench

Write-back stage feeding the 32×32 register file. Accepts results from the ALU and memory paths over valid/ready handshakes, buffers them in a small in-order FIFO and retires one per cycle as a registered one-hot write enable plus write data. Also publishes a pending-write scoreboard for hazard detection and, optionally, bypass data for in-flight writes.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 59 +++++
 rtl/reg_writeback.sv | 145 ++++++++++++++
 tb/tb_reg_writeback.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back stage.
//   REG_ADDR_W / NUM_REGS : register-file geometry (32 x 32)
//   WB_DATA_W             : default data width of a write-back entry
//   wb_entry_t            : destination + data payload of one pending write
//   onehot32()            : destination index to one-hot write enable
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WB_DATA_W  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_ADDR_W-1:0] dest);
    return NUM_REGS'(1) << dest;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending writes.
//   push / push_entry : write one entry at the tail (caller never pushes when full)
//   pop               : drop the head entry (caller never pops when empty)
//   head              : oldest entry
//   count             : occupancy, 0..DEPTH
//   age_view          : all slots, slot 0 = oldest, for Busy/bypass scanning
//   age_valid         : bit i set when age_view slot i holds a live entry
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned EW    = 37,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [EW-1:0]       push_entry,
  input  logic                pop,
  output logic [EW-1:0]       head,
  output logic [CNT_W-1:0]    count,
  output logic [DEPTH*EW-1:0] age_view,
  output logic [DEPTH-1:0]    age_valid
);

  logic [EW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Age-ordered view: slot i is the i-th oldest entry
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_age
    assign age_view[i*EW +: EW] = mem[PTR_W'(rd_ptr + PTR_W'(i))];
    assign age_valid[i]         = CNT_W'(i) < count;
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage feeding the 32x32 register file.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_valid/ready/dest/data  : ALU result handshake
//   mem_valid/ready/dest/data  : load result handshake (wins over ALU)
//   hold                       : suppress the FIFO pop this cycle
//   data_in, en                : registered register-file write data / one-hot enable
//   busy                       : pending-write scoreboard per register
//   bypass_addr_x/hit_x/data_x : youngest in-flight data lookup (x = a, b)
// Optional feature macro: WB_BYPASS_EN enables the bypass lookup; without it
// the bypass outputs are tied to zero.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [WIDTH-1:0]      alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [WIDTH-1:0]      mem_data,
  input  logic                  hold,
  output logic [WIDTH-1:0]      data_in,
  output logic [NUM_REGS-1:0]   en,
  output logic [NUM_REGS-1:0]   busy,
  input  logic [REG_ADDR_W-1:0] bypass_addr_a,
  input  logic [REG_ADDR_W-1:0] bypass_addr_b,
  output logic                  bypass_hit_a,
  output logic                  bypass_hit_b,
  output logic [WIDTH-1:0]      bypass_data_a,
  output logic [WIDTH-1:0]      bypass_data_b
);

  localparam int unsigned EW    = REG_ADDR_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]      fifo_count;
  logic [EW-1:0]         head;
  logic [DEPTH*EW-1:0]   age_view;
  logic [DEPTH-1:0]      age_valid;
  logic                  full;
  logic                  empty;
  logic                  mem_fire;
  logic                  alu_fire;
  logic [REG_ADDR_W-1:0] sel_dest;
  logic [WIDTH-1:0]      sel_data;
  logic                  push;
  logic                  pop;

  assign full  = fifo_count == CNT_W'(DEPTH);
  assign empty = fifo_count == '0;

  // Mem has priority; Ready uses the pre-edge count, so no pass-through when full
  assign mem_ready = rst_n & ~full;
  assign alu_ready = mem_ready & ~mem_valid;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_fire  = alu_valid & alu_ready;
  assign sel_dest  = mem_fire ? mem_dest : alu_dest;
  assign sel_data  = mem_fire ? mem_data : alu_data;

  // Writes to r0 complete the handshake but never occupy the FIFO
  assign push = (mem_fire | alu_fire) & (sel_dest != '0);
  assign pop  = ~empty & ~hold;

  wb_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ({sel_dest, sel_data}),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .age_view   (age_view),
    .age_valid  (age_valid)
  );

  // Output stage: one-cycle enable per retired entry, data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      data_in <= '0;
    end else if (pop) begin
      en      <= onehot32(head[EW-1 -: REG_ADDR_W]);
      data_in <= head[WIDTH-1:0];
    end else begin
      en      <= '0;
    end
  end

  // Scoreboard: every live FIFO entry plus the write in the output stage
  always_comb begin
    busy = en;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (age_valid[i]) busy = busy | onehot32(age_view[i*EW + WIDTH +: REG_ADDR_W]);
    end
  end

`ifdef WB_BYPASS_EN
  // Returns {hit, data}; later (younger) matches override earlier ones
  function automatic logic [WIDTH:0] bypass_lookup(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [NUM_REGS-1:0]   out_en,
    input logic [WIDTH-1:0]      out_data,
    input logic [DEPTH*EW-1:0]   view,
    input logic [DEPTH-1:0]      vld
  );
    logic             hit;
    logic [WIDTH-1:0] data;
    hit  = out_en[addr];
    data = out_en[addr] ? out_data : '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld[i] && (view[i*EW + WIDTH +: REG_ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = view[i*EW +: WIDTH];
      end
    end
    if (addr == '0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {bypass_hit_a, bypass_data_a} = bypass_lookup(bypass_addr_a, en, data_in, age_view, age_valid);
    {bypass_hit_b, bypass_data_b} = bypass_lookup(bypass_addr_b, en, data_in, age_view, age_valid);
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_addr_a, bypass_addr_b, age_view};
  assign bypass_hit_a  = 1'b0;
  assign bypass_hit_b  = 1'b0;
  assign bypass_data_a = '0;
  assign bypass_data_b = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: queue-based reference model of the
// FIFO and output stage checked every cycle, plus directed scenarios.
module tb_reg_writeback;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, hold = 1'b0;
  logic [4:0]  alu_dest = '0, mem_dest = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [4:0]  bypass_addr_a = '0, bypass_addr_b = '0;
  logic        alu_ready, mem_ready, bypass_hit_a, bypass_hit_b;
  logic [31:0] data_in, en, busy, bypass_data_a, bypass_data_b;

  reg_writeback #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .hold(hold), .data_in(data_in), .en(en), .busy(busy),
    .bypass_addr_a(bypass_addr_a), .bypass_addr_b(bypass_addr_b),
    .bypass_hit_a(bypass_hit_a), .bypass_hit_b(bypass_hit_b),
    .bypass_data_a(bypass_data_a), .bypass_data_b(bypass_data_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: sb holds accepted entries awaiting retirement
  wb_entry_t   sb[$];
  logic [31:0] m_en = '0;
  logic [31:0] m_data = '0;
  int          m_n;
  logic        m_mr, m_ar;
  wb_entry_t   m_e;
  bit          mon_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      m_en   = '0;
      m_data = '0;
    end else begin
      m_n  = sb.size();
      m_mr = (m_n < DEPTH);
      m_ar = m_mr && !mem_valid;
      if (m_n > 0 && !hold) begin
        m_e    = sb.pop_front();
        m_en   = 32'(1) << m_e.dest;
        m_data = m_e.data;
      end else begin
        m_en = '0;
      end
      if (mem_valid && m_mr) begin
        if (mem_dest != 5'd0) sb.push_back('{dest: mem_dest, data: mem_data});
      end else if (alu_valid && m_ar && alu_dest != 5'd0) begin
        sb.push_back('{dest: alu_dest, data: alu_data});
      end
    end
  end

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = m_en;
    foreach (sb[i]) b = b | (32'(1) << sb[i].dest);
    return b;
  endfunction

  function automatic logic [32:0] model_bp(input logic [4:0] a);
    logic        hit;
    logic [31:0] d;
    hit = m_en[a];
    d   = m_data;
    foreach (sb[i]) if (sb[i].dest == a) begin hit = 1'b1; d = sb[i].data; end
    if (a == 5'd0) hit = 1'b0;
    return {hit, d};
  endfunction

  task automatic check_bp(input string tag, input logic [4:0] a, input logic hit, input logic [31:0] d);
    logic [32:0] r;
`ifdef WB_BYPASS_EN
    r = model_bp(a);
    check({tag, "_hit"}, 32'(hit), 32'(r[32]));
    if (r[32]) check({tag, "_data"}, d, r[31:0]);
`else
    r = '0;
    check({tag, "_hit"}, 32'(hit), 32'(r[32]));
    check({tag, "_data"}, d, r[31:0]);
`endif
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      check("en", en, m_en);
      check("data_in", data_in, m_data);
      check("busy", busy, model_busy());
      check("mem_ready", 32'(mem_ready), 32'(sb.size() < DEPTH));
      check("alu_ready", 32'(alu_ready), 32'((sb.size() < DEPTH) && !mem_valid));
      check_bp("bp_a", bypass_addr_a, bypass_hit_a, bypass_data_a);
      check_bp("bp_b", bypass_addr_b, bypass_hit_b, bypass_data_b);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one transfer (called just after a rising edge), hold until accepted
  task automatic send(input bit is_mem, input logic [4:0] d, input logic [31:0] v, output bit ok);
    logic r;
    ok = 1'b0;
    if (is_mem) begin mem_valid = 1'b1; mem_dest = d; mem_data = v; end
    else        begin alu_valid = 1'b1; alu_dest = d; alu_data = v; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = is_mem ? mem_ready : alu_ready;
      @(posedge clk);
      #1;
      if (r) begin ok = 1'b1; break; end
    end
    if (is_mem) mem_valid = 1'b0; else alu_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    bit   ok;
    logic mr, ar;

    // Reset
    #12;
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_en", en, 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_mem_ready_rel", 32'(mem_ready), 32'd1);
    check("rst_alu_ready_rel", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;

    // Single ALU write to r5
    send(1'b0, 5'd5, 32'hDEADBEEF, ok);
    @(negedge clk);
    check("single_en_T", en, 32'd0);
    check("single_busy_T", busy, 32'h0000_0020);
    @(negedge clk);
    check("single_en_T1", en, 32'h0000_0020);
    check("single_data_T1", data_in, 32'hDEADBEEF);
    check("single_busy_T1", busy, 32'h0000_0020);
    @(negedge clk);
    check("single_en_T2", en, 32'd0);
    check("single_busy_T2", busy, 32'd0);
    check("single_data_hold", data_in, 32'hDEADBEEF);
    idle(2);

    // Mem wins over ALU in the same cycle
    mem_valid = 1'b1; mem_dest = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'h22;
    @(negedge clk);
    check("arb_alu_ready", 32'(alu_ready), 32'd0);
    check("arb_mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("arb_alu_ready2", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    check("arb_en_first", en, 32'h8);
    @(negedge clk);
    check("arb_en_second", en, 32'h10);
    idle(3);

    // Hold with a full FIFO, then drain in order
    hold = 1'b1;
    send(1'b0, 5'd1, 32'h101, ok);
    send(1'b0, 5'd2, 32'h102, ok);
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h103;
    @(negedge clk);
    check("full_alu_ready", 32'(alu_ready), 32'd0);
    check("full_mem_ready", 32'(mem_ready), 32'd0);
    check("full_en_held", en, 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    check("full_ready_prepop", 32'(alu_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_en1", en, 32'h2);
    check("drain_ready_back", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    check("drain_en2", en, 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_en3", en, 32'h8);
    check("drain_data3", data_in, 32'h103);
    idle(3);

    // r0 write is accepted and dropped
    send(1'b0, 5'd0, 32'hFFFFFFFF, ok);
    check("dest0_accept", 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dest0_en", en, 32'd0);
      check("dest0_busy", busy, 32'd0);
    end
    idle(1);

    // Bypass: youngest of two pending writes to r7
    hold = 1'b1;
    send(1'b0, 5'd7, 32'hA, ok);
    send(1'b1, 5'd7, 32'hB, ok);
    bypass_addr_a = 5'd7;
    bypass_addr_b = 5'd0;
    @(negedge clk);
    check("bp_busy", busy, 32'h80);
`ifdef WB_BYPASS_EN
    check("bp_hit_a", 32'(bypass_hit_a), 32'd1);
    check("bp_data_a", bypass_data_a, 32'hB);
`else
    check("bp_hit_a", 32'(bypass_hit_a), 32'd0);
    check("bp_data_a", bypass_data_a, 32'd0);
`endif
    check("bp_hit_b", 32'(bypass_hit_b), 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    idle(4);

    // Random traffic; sources keep payload stable while not accepted
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      mr = mem_ready;
      ar = alu_ready;
      @(posedge clk); #1;
      if (!mem_valid || mr) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_dest  = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      if (!alu_valid || ar) begin
        alu_valid = ($urandom_range(0, 1) == 0);
        alu_dest  = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      hold          = ($urandom_range(0, 3) == 0);
      bypass_addr_a = 5'($urandom_range(0, 7));
      bypass_addr_b = 5'($urandom_range(0, 7));
    end
    @(negedge clk);
    mr = mem_ready;
    ar = alu_ready;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    hold      = 1'b0;
    idle(6);

    // Asynchronous reset with writes pending
    hold = 1'b1;
    send(1'b0, 5'd9, 32'h99, ok);
    send(1'b0, 5'd10, 32'hAA, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_ready", 32'(mem_ready), 32'd0);
    check("arst_alu_ready", 32'(alu_ready), 32'd0);
    check("arst_busy", busy, 32'd0);
    check("arst_en", en, 32'd0);
    check("arst_data_in", data_in, 32'd0);
    @(posedge clk); #1;
    hold  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_busy_after", busy, 32'd0);
    idle(3);
    check("arst_en_after", en, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
